vga_rx: RTL and testbench

VGA_RX -- requirements
Module: vga_rx

---
 rtl/vga_rx.sv | 146 ++++++++++++++
 tb/tb_vga_rx.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/vga_rx.sv
// rtl/vga_rx.sv - VGA sync receiver: locks onto HS/VS timing and decodes active pixels
module vga_rx #(
  parameter int H_TOTAL = 800,
  parameter int H_START = 144,
  parameter int V_TOTAL = 525,
  parameter int V_START = 35
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        HS,
  input  logic        VS,
  input  logic [3:0]  R,
  input  logic [3:0]  G,
  input  logic [3:0]  B,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [11:0] pix_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic        err_h,
  output logic        err_v,
  output logic [7:0]  frame_count
);

  localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_OFS  = 10'(H_START);
  localparam logic [9:0]  V_OFS  = 10'(V_START);
  localparam logic [10:0] H_LO   = 11'(H_START);
  localparam logic [10:0] H_HI   = 11'(H_START + 640);
  localparam logic [10:0] V_LO   = 11'(V_START);
  localparam logic [10:0] V_HI   = 11'(V_START + 480);
  localparam logic [9:0]  CNT_MAX = 10'h3ff;

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t     state;
  logic       hs_d, vs_d, sticky;
  logic [9:0] h_cnt, v_cnt;

  logic       fall_h, fall_v;
  logic [9:0] h_nxt, v_nxt, x_rel, y_rel;
  logic       line_fault, frame_fault, in_window, stay_locked;

  always_comb begin
    fall_h = hs_d & ~HS;
    fall_v = vs_d & ~VS;

    h_nxt = h_cnt;
    if (fall_h)
      h_nxt = '0;
    else if (h_cnt != CNT_MAX)
      h_nxt = h_cnt + 10'd1;

    v_nxt = v_cnt;
    if (fall_v)
      v_nxt = '0;
    else if (fall_h && v_cnt != CNT_MAX)
      v_nxt = v_cnt + 10'd1;

    // A runaway line is flagged once, on the edge where h_cnt saturates.
    line_fault  = (fall_h && h_cnt != H_LAST) || (!fall_h && h_cnt == CNT_MAX - 10'd1);
    frame_fault = fall_v && v_cnt != V_LAST;

    in_window = ({1'b0, h_nxt} >= H_LO) && ({1'b0, h_nxt} < H_HI) &&
                ({1'b0, v_nxt} >= V_LO) && ({1'b0, v_nxt} < V_HI);
    stay_locked = (state == LOCKED) && !line_fault && !frame_fault;
    x_rel = h_nxt - H_OFS;
    y_rel = v_nxt - V_OFS;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SEARCH;
      hs_d        <= 1'b0;
      vs_d        <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      sticky      <= 1'b0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      err_h       <= 1'b0;
      err_v       <= 1'b0;
      frame_count <= '0;
    end else begin
      hs_d        <= HS;
      vs_d        <= VS;
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      frame_start <= 1'b0;
      err_h       <= 1'b0;
      err_v       <= 1'b0;

      case (state)
        SEARCH: begin
          if (fall_v) begin
            state  <= ACQUIRE;
            sticky <= 1'b0;
          end
        end
        ACQUIRE: begin
          if (fall_v) begin
            sticky <= 1'b0;
            if (!frame_fault && !sticky && !line_fault) begin
              state       <= LOCKED;
              locked      <= 1'b1;
              frame_start <= 1'b1;
              frame_count <= frame_count + 8'd1;
            end
          end else if (line_fault) begin
            sticky <= 1'b1;
          end
        end
        LOCKED: begin
          if (fall_v && !frame_fault) begin
            frame_start <= 1'b1;
            frame_count <= frame_count + 8'd1;
          end
          if (line_fault || frame_fault) begin
            err_h  <= line_fault;
            err_v  <= frame_fault;
            state  <= SEARCH;
            locked <= 1'b0;
          end
        end
        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase

      pix_valid <= stay_locked && in_window;
      if (stay_locked && in_window) begin
        pix_x   <= x_rel;
        pix_y   <= y_rel[8:0];
        pix_rgb <= {R, G, B};
      end
    end
  end

endmodule

// File: tb/tb_vga_rx.sv
// tb/tb_vga_rx.sv - scoreboard bench for vga_rx on shortened frame timings
module tb_vga_rx;

  localparam int HT = 656, HST = 8, VT = 4, VST = 1;
  localparam int WHT = 8, WHST = 2, WVT = 4, WVST = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        HS, VS;
  logic [3:0]  R, G, B;

  logic        pix_valid, frame_start, locked, err_h, err_v;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [11:0] pix_rgb;
  logic [7:0]  frame_count;

  logic        w_pix_valid, w_frame_start, w_locked, w_err_h, w_err_v;
  logic [9:0]  w_pix_x;
  logic [8:0]  w_pix_y;
  logic [11:0] w_pix_rgb;
  logic [7:0]  w_frame_count;

  vga_rx #(.H_TOTAL(HT), .H_START(HST), .V_TOTAL(VT), .V_START(VST)) dut (
    .clk(clk), .rst(rst), .HS(HS), .VS(VS), .R(R), .G(G), .B(B),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .frame_start(frame_start), .locked(locked), .err_h(err_h), .err_v(err_v),
    .frame_count(frame_count)
  );

  // Tiny frame geometry so the frame counter can wrap in a short run.
  vga_rx #(.H_TOTAL(WHT), .H_START(WHST), .V_TOTAL(WVT), .V_START(WVST)) dut_w (
    .clk(clk), .rst(rst), .HS(HS), .VS(VS), .R(R), .G(G), .B(B),
    .pix_valid(w_pix_valid), .pix_x(w_pix_x), .pix_y(w_pix_y), .pix_rgb(w_pix_rgb),
    .frame_start(w_frame_start), .locked(w_locked), .err_h(w_err_h), .err_v(w_err_v),
    .frame_count(w_frame_count)
  );

  always #20 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int tick_no = 0;
  int errh_cnt, errv_cnt, both_cnt, fs_cnt, errh_tick;
  bit pix_mode;
  logic lk_first;
  logic [30:0] sb_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr_counts();
    errh_cnt = 0; errv_cnt = 0; both_cnt = 0; fs_cnt = 0; errh_tick = -1;
  endtask

  task automatic tick();
    logic [30:0] e;
    @(posedge clk);
    #1;
    tick_no++;
    if (pix_mode) begin
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("pix", 64'({pix_valid, pix_x, pix_y, pix_rgb}), 64'({1'b1, e}));
      end else if (pix_valid) begin
        chk("pix_extra", 64'(pix_valid), 64'd0);
      end
    end
    if (err_h) begin
      chk("errh_unlock", 64'(locked), 64'd0);
      if (errh_tick < 0) errh_tick = tick_no;
    end
    errh_cnt += int'(err_h);
    errv_cnt += int'(err_v);
    both_cnt += int'(err_h & err_v);
    fs_cnt   += int'(frame_start);
  endtask

  task automatic drive_line(input int len, input int l, input bit push);
    logic [11:0] rgb;
    for (int c = 0; c < len; c++) begin
      HS = (c >= 2);
      VS = (l != 0);
      rgb = (c == HST && l == VST) ? 12'hA53 : 12'($urandom);
      {R, G, B} = rgb;
      if (push && l >= VST && l < VST + 480 && c >= HST && c < HST + 640)
        sb_q.push_back({10'(c - HST), 9'(l - VST), rgb});
      tick();
      if (c == 0) lk_first = locked;
    end
  endtask

  task automatic frame(input int ht, input int vt, input int short_line, input int push_lines);
    for (int l = 0; l < vt; l++)
      drive_line((l == short_line) ? ht - 1 : ht, l, l < push_lines);
  endtask

  initial begin
    int hold_base;
    rst = 1'b1; HS = 1'b0; VS = 1'b0; {R, G, B} = '0;
    pix_mode = 1'b1;
    clr_counts();
    repeat (3) tick();
    chk("reset", 64'({pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked,
                      err_h, err_v, frame_count}), 64'd0);
    rst = 1'b0;
    repeat (2) tick();
    HS = 1'b1; VS = 1'b1;
    repeat (3) tick();

    frame(HT, VT, -1, 0);
    chk("acquire_not_locked", 64'(locked), 64'd0);
    frame(HT, VT, -1, VT);
    chk("lock_rise", 64'(lk_first), 64'd1);
    frame(HT, VT, -1, VT);
    chk("fc_3frames", 64'(frame_count), 64'd2);
    chk("fs_count", 64'(fs_cnt), 64'd2);
    chk("hold_xy", 64'({pix_x, pix_y}), 64'({10'd639, 9'd2}));

    // Short line mid-frame
    clr_counts();
    frame(HT, VT, 1, 2);
    frame(HT, VT, -1, 0);
    chk("relock_pending", 64'(locked), 64'd0);
    frame(HT, VT, -1, VT);
    chk("short_line_errs", 64'({errh_cnt[7:0], errv_cnt[7:0]}), 64'({8'd1, 8'd0}));
    chk("relocked", 64'(locked), 64'd1);
    chk("fc_relock", 64'(frame_count), 64'd4);

    // Frame one line short, its last line also short
    clr_counts();
    frame(HT, VT - 1, VT - 2, VT - 1);
    frame(HT, VT, -1, 0);
    frame(HT, VT, -1, 0);
    frame(HT, VT, -1, VT);
    chk("both_errs", 64'({both_cnt[7:0], errv_cnt[7:0]}), 64'({8'd1, 8'd1}));
    chk("fc_short_frame", 64'(frame_count), 64'd6);

    // HS stuck high
    clr_counts();
    HS = 1'b1; VS = 1'b1;
    hold_base = tick_no;
    repeat (1100) tick();
    chk("stuck_errh", 64'(errh_cnt), 64'd1);
    chk("stuck_errh_time", 64'(errh_tick - hold_base), 64'(1023 - (HT - 1)));
    chk("stuck_unlock", 64'(locked), 64'd0);

    // Reset in the middle of an active line
    frame(HT, VT, -1, 0);
    frame(HT, VT, -1, VT);
    drive_line(HT, 0, 1'b1);
    drive_line(300, 1, 1'b1);
    chk("pre_rst", 64'({locked, frame_count}), 64'({1'b1, 8'd8}));
    rst = 1'b1;
    tick();
    chk("rst_mid", 64'({pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked,
                        err_h, err_v, frame_count}), 64'd0);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    // Counter wrap on the small instance
    pix_mode = 1'b0;
    sb_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    HS = 1'b1; VS = 1'b1;
    repeat (3) tick();
    for (int f = 1; f <= 257; f++) begin
      frame(WHT, WVT, -1, 0);
      if (f == 2) chk("w_fc1", 64'({w_locked, w_frame_count}), 64'({1'b1, 8'd1}));
      if (f == 256) chk("w_fc255", 64'(w_frame_count), 64'd255);
    end
    chk("w_fc_wrap", 64'({w_locked, w_frame_count}), 64'({1'b1, 8'd0}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
